// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Size encodings, FSM states and the byte-enable helper.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    function automatic logic [LANES-1:0] be_mask(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [LANES-1:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m = LANES'(1) << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = '1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word-organised data RAM with per-byte write enables.
// Read port is registered; no reset on contents.
module dmem_ram_bank #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clka,
    input  logic                re,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: handshake FSM, alignment checks, extension.
// Optional DMEM_PERF_CNT_EN adds ld_cnt/st_cnt counters.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int READ_LAT    = 1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       ld_cnt,
    output logic [31:0]       st_cnt
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] DEPTH_L = IW'(DEPTH_WORDS);

    state_t state, state_nx;
    logic [1:0] cnt, cnt_nx;

    logic          acc;
    logic [1:0]    a_lo;
    logic [IW-1:0] idx;
    logic          misal, bad_sz, oob, err;
    logic          ram_we, ram_re;
    logic [NB-1:0] be;
    logic [DATA_W-1:0] wrep, ram_rdata, rd_word, ld_val;

    logic [1:0] sz_q, lo_q;
    logic       uns_q, we_q, err_q;

    assign acc  = req_valid && req_ready;
    assign a_lo = req_addr[1:0];
    assign idx  = req_addr[ADDR_W-1:2];

    assign misal  = (req_size == SZ_HALF && a_lo[0])
                 || (req_size == SZ_WORD && a_lo != 2'b00);
    assign bad_sz = (req_size == 2'b11);
    assign oob    = (idx >= DEPTH_L);
    assign err    = misal || bad_sz || oob;

    assign ram_we = acc && req_we && !err;
    assign ram_re = acc && !req_we && !err;
    assign be     = NB'(be_mask(req_size, a_lo));

    always_comb begin
        wrep = req_wdata;
        case (req_size)
            SZ_BYTE: wrep = {NB{req_wdata[7:0]}};
            SZ_HALF: wrep = {(NB/2){req_wdata[15:0]}};
            default: wrep = req_wdata;
        endcase
    end

    dmem_ram_bank #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clka  (clka),
        .re    (ram_re),
        .we    (ram_we),
        .be    (be),
        .addr  (idx[AW-1:0]),
        .wdata (wrep),
        .rdata (ram_rdata)
    );

    // Response context captured at acceptance.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            sz_q  <= SZ_BYTE;
            lo_q  <= 2'b00;
            uns_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (acc) begin
            sz_q  <= req_size;
            lo_q  <= a_lo;
            uns_q <= req_unsigned;
            we_q  <= req_we;
            err_q <= err;
        end
    end

    generate
        if (READ_LAT > 1) begin : g_pipe
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clka or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (state == RD_WAIT) begin
                    rd_q <= ram_rdata;
                end
            end
            assign rd_word = rd_q;
        end else begin : g_direct
            assign rd_word = ram_rdata;
        end
    endgenerate

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, RESP: begin
                if (acc) begin
                    if (err || req_we || READ_LAT == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = RD_WAIT;
                        cnt_nx   = 2'(READ_LAT - 1);
                    end
                end else if (state == RESP) begin
                    state_nx = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt <= 2'd1) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        case (state)
            RD_WAIT: req_ready = 1'b0;
            RESP:    rsp_valid = 1'b1;
            default: begin
                req_ready = 1'b1;
                rsp_valid = 1'b0;
            end
        endcase
    end

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rd_word[{lo_q, 3'b000} +: 8];
    assign lane_h = rd_word[{lo_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = '0;
        unique case (1'b1)
            (sz_q == SZ_BYTE):
                ld_val = {{(DATA_W-8){~uns_q & lane_b[7]}}, lane_b};
            (sz_q == SZ_HALF):
                ld_val = {{(DATA_W-16){~uns_q & lane_h[15]}}, lane_h};
            (sz_q == SZ_WORD):
                ld_val = rd_word;
            default:
                ld_val = '0;
        endcase
    end

    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_val : '0;
    assign rsp_err   = rsp_valid && err_q;

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (acc && !err) begin
            if (req_we) begin
                st_cnt <= st_cnt + 32'd1;
            end else begin
                ld_cnt <= ld_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (READ_LAT=1/DEPTH=1024 and
// READ_LAT=2/DEPTH=16) driven in lockstep, scoreboarded per instance.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clka = 1'b0;
    logic rst  = 1'b0;
    always #5 clka = ~clka;

    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        a_ready, a_valid, a_err;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_err;
    logic [31:0] b_rdata;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] a_ld, a_st, b_ld, b_st;
`endif

    dmem_lsu #(.DEPTH_WORDS(1024), .READ_LAT(1)) u_a (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(a_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
`ifdef DMEM_PERF_CNT_EN
        , .ld_cnt(a_ld), .st_cnt(a_st)
`endif
    );

    dmem_lsu #(.DEPTH_WORDS(16), .READ_LAT(2)) u_b (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(b_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
`ifdef DMEM_PERF_CNT_EN
        , .ld_cnt(b_ld), .st_cnt(b_st)
`endif
    );

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_a;
        logic        err_a;
        logic [31:0] rd_b;
        logic        err_b;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[$];
    vec_t tbl2[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_lds = 0, a_sts = 0, b_lds = 0, b_sts = 0;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h (cyc %0d)",
                     name, act, want, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz,
        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
        input logic [31:0] rda, input logic ea,
        input logic [31:0] rdb, input logic eb);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wdata = wd; v.rd_a = rda; v.err_a = ea;
        v.rd_b = rdb; v.err_b = eb;
        return v;
    endfunction

    exp_t ea, eb;

    always @(negedge clka) begin
        if (!rst) begin
            if (a_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rdata", a_rdata, ea.rd);
                    chk("a_err", {31'd0, a_err}, {31'd0, ea.err});
                    chk("a_latency", 32'(cyc), 32'(ea.cyc));
                end
            end else if (qa.size() != 0 && qa[0].cyc < cyc) begin
                chk("a_missing_rsp", 32'(cyc), 32'(qa[0].cyc));
                void'(qa.pop_front());
            end
            if (b_valid) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_rdata", b_rdata, eb.rd);
                    chk("b_err", {31'd0, b_err}, {31'd0, eb.err});
                    chk("b_latency", 32'(cyc), 32'(eb.cyc));
                end
            end else if (qb.size() != 0 && qb[0].cyc < cyc) begin
                chk("b_missing_rsp", 32'(cyc), 32'(qb[0].cyc));
                void'(qb.pop_front());
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic send(input vec_t v, input bit track);
        exp_t e;
        int n;
        n = 0;
        req_valid = 1'b0;
        while (!(a_ready && b_ready) && n < 20) begin
            @(posedge clka);
            #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
        req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        if (track) begin
            e.rd = v.rd_a; e.err = v.err_a; e.cyc = cyc + 1;
            qa.push_back(e);
            e.rd = v.rd_b; e.err = v.err_b;
            e.cyc = cyc + ((v.we || v.err_b) ? 1 : 2);
            qb.push_back(e);
        end
        if (!v.err_a) begin
            if (v.we) a_sts++; else a_lds++;
        end
        if (!v.err_b) begin
            if (v.we) b_sts++; else b_lds++;
        end
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        if (!v.we && !v.err_b) begin
            chk("b_ready_rd_wait", {31'd0, b_ready}, 32'd0);
            chk("a_ready_after_ld", {31'd0, a_ready}, 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_ready"}, {31'd0, a_ready}, 32'd1);
        chk({tag, "_b_ready"}, {31'd0, b_ready}, 32'd1);
        chk({tag, "_a_valid"}, {31'd0, a_valid}, 32'd0);
        chk({tag, "_b_valid"}, {31'd0, b_valid}, 32'd0);
        chk({tag, "_a_rdata"}, a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, b_rdata, 32'd0);
        chk({tag, "_a_err"}, {31'd0, a_err}, 32'd0);
        chk({tag, "_b_err"}, {31'd0, b_err}, 32'd0);
    endtask

    task automatic check_cnt(input string tag);
`ifdef DMEM_PERF_CNT_EN
        chk({tag, "_a_ld_cnt"}, a_ld, 32'(a_lds));
        chk({tag, "_a_st_cnt"}, a_st, 32'(a_sts));
        chk({tag, "_b_ld_cnt"}, b_ld, 32'(b_lds));
        chk({tag, "_b_st_cnt"}, b_st, 32'(b_sts));
`else
        chk({tag, "_no_cnt_a_ready"}, {31'd0, a_ready}, 32'd1);
`endif
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // we sz uns addr wdata | A rdata err | B rdata err
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 0, 0, 0));
        tbl.push_back(mk(1, SZ_BYTE, 0, 32'h13, 32'h00000080, 0, 0, 0, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h13, 0, 32'hFFFFFF80, 0, 32'hFFFFFF80, 0));
        tbl.push_back(mk(0, SZ_BYTE, 1, 32'h13, 0, 32'h00000080, 0, 32'h00000080, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'h80223344, 0, 32'h80223344, 0));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h11, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h12, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, SZ_HALF, 0, 32'h11, 32'h0000AAAA, 0, 1, 0, 1));
        tbl.push_back(mk(1, 2'b11, 0, 32'h10, 32'h55555555, 0, 1, 0, 1));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'h80223344, 0, 32'h80223344, 0));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h12, 0, 32'hFFFF8022, 0, 32'hFFFF8022, 0));
        tbl.push_back(mk(0, SZ_HALF, 1, 32'h10, 0, 32'h00003344, 0, 32'h00003344, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h10, 0, 32'h00000044, 0, 32'h00000044, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h00, 32'h12345678, 0, 0, 0, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0, 1));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h00, 0, 32'h12345678, 0, 32'h12345678, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h40, 0, 32'hCAFEF00D, 0, 0, 1));
        tbl.push_back(mk(0, 2'b11, 0, 32'h00, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h20, 32'h55667788, 0, 0, 0, 0));
        tbl.push_back(mk(1, SZ_HALF, 0, 32'h22, 32'h1234BEEF, 0, 0, 0, 0));
        tbl.push_back(mk(1, SZ_BYTE, 0, 32'h21, 32'hFFFFFF01, 0, 0, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h20, 0, 32'hBEEF0188, 0, 32'hBEEF0188, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h22, 0, 32'hFFFFFFEF, 0, 32'hFFFFFFEF, 0));
        tbl.push_back(mk(0, SZ_BYTE, 1, 32'h23, 0, 32'h000000BE, 0, 32'h000000BE, 0));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h20, 0, 32'h00000188, 0, 32'h00000188, 0));
        tbl.push_back(mk(0, SZ_HALF, 1, 32'h22, 0, 32'h0000BEEF, 0, 32'h0000BEEF, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, SZ_WORD, 0, 32'h30 + 32'(4*i),
                             32'h01010101 * 32'(i+1), 0, 0, 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, SZ_WORD, 0, 32'h30 + 32'(4*i), 0,
                             32'h01010101 * 32'(i+1), 0,
                             32'h01010101 * 32'(i+1), 0));
        end

        tbl2.push_back(mk(0, SZ_WORD, 0, 32'h2C, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0));
        tbl2.push_back(mk(1, SZ_WORD, 0, 32'h04, 32'hA1B2C3D4, 0, 0, 0, 0));
        tbl2.push_back(mk(1, SZ_BYTE, 0, 32'h05, 32'h00000077, 0, 0, 0, 0));
        tbl2.push_back(mk(1, SZ_HALF, 0, 32'h06, 32'h00009999, 0, 0, 0, 0));
        tbl2.push_back(mk(1, SZ_WORD, 0, 32'h41, 32'hFFFFFFFF, 0, 1, 0, 1));
        tbl2.push_back(mk(0, SZ_WORD, 0, 32'h04, 0, 32'h999977D4, 0, 32'h999977D4, 0));

        #1 rst = 1'b1;
        repeat (2) @(posedge clka);
        #1;
        check_idle("reset");
        check_cnt("reset");
        rst = 1'b0;
        @(posedge clka);
        #1;

        foreach (tbl[i]) send(tbl[i], 1'b1);
        repeat (4) @(posedge clka);
        #1;
        check_cnt("table");

        // Store accepted right before reset must survive it.
        send(mk(1, SZ_WORD, 0, 32'h2C, 32'h5A5A5A5A, 0, 0, 0, 0), 1'b0);
        rst = 1'b1;
        #1;
        check_idle("rst_after_st");
        @(posedge clka);
        #1;
        rst = 1'b0;

        // Load caught in RD_WAIT on the READ_LAT=2 instance is dropped.
        send(mk(0, SZ_WORD, 0, 32'h00, 0, 0, 0, 0, 0), 1'b0);
        rst = 1'b1;
        #1;
        check_idle("rst_in_wait");
        @(posedge clka);
        #1;
        rst = 1'b0;
        @(posedge clka);
        #1;
        check_idle("post_rst");
        a_lds = 0; a_sts = 0; b_lds = 0; b_sts = 0;
        check_cnt("post_rst");

        foreach (tbl2[i]) send(tbl2[i], 1'b1);
        repeat (4) @(posedge clka);
        #1;
        check_cnt("final");
`ifdef DMEM_PERF_CNT_EN
        chk("b_st_cnt_three", b_st, 32'd3);
`endif
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
